s838_run_ctrl: RTL and testbench

Sequencer and state holder for the s838 combinational next-state core. It owns the 32-bit Y state register, drives the core's X and Clear inputs, and samples the core's Z and W outputs. It runs a requested number of count steps under a start/done handshake, with hold, abort and preset support. It sits between the test/emulation host logic and the core; the core's next-state outputs come back to it as a 32-bit bus.

---
 rtl/s838_run_ctrl_if.sv | 42 ++++
 rtl/s838_run_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_s838_run_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s838_run_ctrl_if.sv
// Host and core signal bundle for s838_run_ctrl.
// The master modport is the host/core side; the slave modport is the sequencer.
interface s838_run_ctrl_if #(
    parameter int unsigned STEP_W = 16
);
    // host request side
    logic              start;
    logic [STEP_W-1:0] steps;
    logic              clear_first;
    logic              hold;
    logic              abort;
    logic              ld_en;
    logic [31:0]       ld_data;

    // core return side
    logic [31:0]       ns_in;
    logic              z_in;
    logic              w_in;

    // sequencer outputs
    logic [31:0]       y_out;
    logic              x_out;
    logic              clear_out;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [STEP_W-1:0] z_count;
    logic              w_seen;
    logic [15:0]       sig;

    modport master (
        output start, steps, clear_first, hold, abort, ld_en, ld_data,
        output ns_in, z_in, w_in,
        input  y_out, x_out, clear_out, busy, done, aborted, z_count, w_seen, sig
    );

    modport slave (
        input  start, steps, clear_first, hold, abort, ld_en, ld_data,
        input  ns_in, z_in, w_in,
        output y_out, x_out, clear_out, busy, done, aborted, z_count, w_seen, sig
    );
endinterface

// File: rtl/s838_run_ctrl.sv
// Run sequencer and Y state holder for the s838 next-state core.
// Optional Z signature (CRC-CCITT) is compiled in with `define S838_SIG_EN.
module s838_run_ctrl #(
    parameter int unsigned STEP_W = 16
) (
    input  logic             CK,
    input  logic             RSTn,
    s838_run_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_nxt;

    logic [31:0]       y_q;
    logic [STEP_W-1:0] remaining_q;
    logic [STEP_W-1:0] z_count_q;
    logic              w_seen_q;
    logic              aborted_q;

    logic              x_q;
    logic              clear_q;
    logic              busy_q;
    logic              done_q;
    logic              x_d;
    logic              clear_d;
    logic              busy_d;
    logic              done_d;

    logic              accept_c;
    logic              abort_c;
    logic              load_c;
    logic              step_c;

    // Qualified events for the datapath; hold only stalls RUN, abort wins over everything.
    always_comb begin
        accept_c = (state_q == S_IDLE) && bus.start;
        abort_c  = ((state_q == S_CLR) || (state_q == S_RUN)) && bus.abort;
        step_c   = (state_q == S_RUN) && !bus.abort && !bus.hold;
        load_c   = ((state_q == S_CLR) && !bus.abort) || step_c;
    end

    // State register.
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.steps == '0) begin
                        state_nxt = S_DONE;
                    end else if (bus.clear_first) begin
                        state_nxt = S_CLR;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_CLR: begin
                state_nxt = bus.abort ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_nxt = S_DONE;
                end else if (!bus.hold && (remaining_q == STEP_W'(1))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state, registered below so outputs never see inputs directly.
    always_comb begin
        x_d     = 1'b0;
        clear_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_nxt)
            S_CLR: begin
                x_d     = 1'b1;
                clear_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_RUN: begin
                x_d     = 1'b1;
                busy_d  = 1'b1;
            end
            S_DONE: begin
                done_d  = 1'b1;
            end
            default: begin
                x_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            x_q     <= 1'b0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            clear_q <= clear_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Y register: preset only in IDLE, otherwise follows the core on load cycles.
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            y_q <= 32'h0000_0000;
        end else if ((state_q == S_IDLE) && bus.ld_en) begin
            y_q <= bus.ld_data;
        end else if (load_c) begin
            y_q <= bus.ns_in;
        end
    end

    // Step counter and observation of the core outputs on sampled steps.
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            remaining_q <= '0;
            z_count_q   <= '0;
            w_seen_q    <= 1'b0;
            aborted_q   <= 1'b0;
        end else if (accept_c) begin
            remaining_q <= bus.steps;
            z_count_q   <= '0;
            w_seen_q    <= 1'b0;
            aborted_q   <= 1'b0;
        end else if (abort_c) begin
            aborted_q   <= 1'b1;
        end else if (step_c) begin
            remaining_q <= remaining_q - STEP_W'(1);
            if (bus.z_in && (z_count_q != '1)) begin
                z_count_q <= z_count_q + STEP_W'(1);
            end
            w_seen_q    <= w_seen_q | bus.w_in;
        end
    end

`ifdef S838_SIG_EN
    logic [15:0] sig_q;
    logic        sig_fb_c;

    assign sig_fb_c = sig_q[15] ^ bus.z_in;

    // CRC-CCITT (0x1021) signature over the sampled Z stream.
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            sig_q <= 16'h0000;
        end else if (accept_c) begin
            sig_q <= 16'hFFFF;
        end else if (step_c) begin
            sig_q <= {sig_q[14:0], 1'b0} ^ (sig_fb_c ? 16'h1021 : 16'h0000);
        end
    end

    assign bus.sig = sig_q;
`else
    assign bus.sig = 16'h0000;
`endif

    assign bus.y_out     = y_q;
    assign bus.x_out     = x_q;
    assign bus.clear_out = clear_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.z_count   = z_count_q;
    assign bus.w_seen    = w_seen_q;

endmodule

// File: tb/tb_s838_run_ctrl.sv
// Scoreboard bench for s838_run_ctrl with a behavioural counter standing in for the core.
module tb_s838_run_ctrl;
    localparam int unsigned STEP_W = 16;
    localparam int          BUDGET = 400;

    logic ck    = 1'b0;
    logic rst_n = 1'b0;

    always #5 ck = ~ck;

    s838_run_ctrl_if #(.STEP_W(STEP_W)) bus ();

    s838_run_ctrl #(.STEP_W(STEP_W)) dut (
        .CK   (ck),
        .RSTn (rst_n),
        .bus  (bus)
    );

    // Core stand-in: counts up while X=1 and Clear=0, zero otherwise.
    assign bus.ns_in = (bus.x_out && !bus.clear_out) ? (bus.y_out + 32'd1) : 32'h0000_0000;
    assign bus.z_in  = bus.y_out[0];
    assign bus.w_in  = (bus.y_out == 32'hFFFF_FFFF);

    typedef struct {
        string       name;
        logic [31:0] y;
        logic [15:0] zc;
        logic        w;
        logic        ab;
        logic [15:0] sig;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] model_y = 32'h0;

    function automatic logic [15:0] crc_step(input logic [15:0] s, input logic z);
        logic fb;
        fb = s[15] ^ z;
        return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.steps       = '0;
        bus.clear_first = 1'b0;
        bus.hold        = 1'b0;
        bus.abort       = 1'b0;
        bus.ld_en       = 1'b0;
        bus.ld_data     = 32'h0;
    endtask

    // Edges are numbered from the accepting edge (0); hold covers edges [h0, h0+hl), abort hits edge ab_at.
    task automatic run_case(input string name, input int n, input bit clr, input bit pre,
                            input logic [31:0] pdata, input int h0, input int hl,
                            input int ab_at, input bit noise);
        exp_t        ex;
        logic [31:0] ycur;
        logic [15:0] sg;
        int          zc;
        int          e;
        int          loads;
        bit          got;
        bit          in_hold;
        logic [3:0]  ctl_exp;
        logic [31:0] prev_y;

        ycur = pre ? pdata : model_y;
        zc = 0; loads = 0; sg = 16'hFFFF;
        ex.name = name; ex.w = 1'b0; ex.ab = 1'b0; ex.lat = -1;
        if (n == 0) begin
            ex.lat = 0;
        end else begin
            e = 1;
            if (clr) begin
                if (ab_at == 1) begin
                    ex.ab = 1'b1; ex.lat = 1;
                end else begin
                    ycur = 32'h0; e = 2;
                end
            end
            while (ex.lat < 0) begin
                if (e == ab_at) begin
                    ex.ab = 1'b1; ex.lat = e;
                end else if (!(e >= h0 && e < h0 + hl)) begin
                    if (ycur[0]) zc++;
                    if (ycur == 32'hFFFF_FFFF) ex.w = 1'b1;
                    sg = crc_step(sg, ycur[0]);
                    ycur = ycur + 32'd1;
                    loads++;
                    if (loads == n) ex.lat = e;
                end
                e++;
            end
        end
        ex.y  = ycur;
        ex.zc = 16'(zc);
`ifdef S838_SIG_EN
        ex.sig = sg;
`else
        ex.sig = 16'h0000;
`endif
        model_y = ycur;
        sb.push_back(ex);

        bus.start = 1'b1; bus.steps = STEP_W'(n); bus.clear_first = clr;
        bus.ld_en = pre; bus.ld_data = pdata;
        bus.hold = 1'b0; bus.abort = (ab_at == 0);
        @(posedge ck); #1;
        e = 0; got = 1'b0;
        prev_y = bus.y_out;
        while (!got && e < BUDGET) begin
            ctl_exp[3] = (n != 0) && (e < ex.lat);
            ctl_exp[2] = ctl_exp[3];
            ctl_exp[1] = clr && (n != 0) && (e == 0);
            ctl_exp[0] = (e == ex.lat);
            vectors++;
            if ({bus.busy, bus.x_out, bus.clear_out, bus.done} !== ctl_exp) begin
                errors++;
                $display("FAIL %s ctl{busy,x,clr,done} cycle %0d got %b exp %b", name, e,
                         {bus.busy, bus.x_out, bus.clear_out, bus.done}, ctl_exp);
            end
            in_hold = (e >= h0) && (e < h0 + hl) && (e >= 1) && (e < ex.lat) && !(clr && e == 1);
            if (in_hold) begin
                vectors++;
                if (bus.y_out !== prev_y) begin
                    errors++;
                    $display("FAIL %s hold_y cycle %0d got %h exp %h", name, e, bus.y_out, prev_y);
                end
            end
            if (bus.done === 1'b1) begin
                got = 1'b1;
                ex = sb.pop_front();
                vectors++;
                if (e !== ex.lat) begin
                    errors++;
                    $display("FAIL %s latency got %0d exp %0d", name, e, ex.lat);
                end
                vectors++;
                if ({bus.y_out, bus.z_count, bus.w_seen, bus.aborted, bus.sig} !==
                    {ex.y, ex.zc, ex.w, ex.ab, ex.sig}) begin
                    errors++;
                    $display("FAIL %s result y/zc/w/ab/sig got %h/%0d/%b/%b/%h exp %h/%0d/%b/%b/%h",
                             name, bus.y_out, bus.z_count, bus.w_seen, bus.aborted, bus.sig,
                             ex.y, ex.zc, ex.w, ex.ab, ex.sig);
                end
            end
            prev_y = bus.y_out;
            if (noise && !got) begin
                bus.start   = 1'b1;
                bus.ld_en   = 1'b1;
                bus.ld_data = $urandom;
            end else begin
                bus.start = 1'b0;
                bus.ld_en = 1'b0;
            end
            bus.hold  = !got && (e + 1 >= h0) && (e + 1 < h0 + hl);
            bus.abort = !got && (e + 1 == ab_at);
            @(posedge ck); #1;
            e++;
        end
        idle_inputs();
        if (!got) begin
            errors++;
            $display("FAIL %s timeout no done within %0d cycles", name, BUDGET);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            vectors++;
            if ({bus.busy, bus.done, bus.aborted, bus.y_out} !== {1'b0, 1'b0, ex.ab, ex.y}) begin
                errors++;
                $display("FAIL %s idle_after got busy=%b done=%b ab=%b y=%h exp 0/0/%b/%h",
                         name, bus.busy, bus.done, bus.aborted, bus.y_out, ex.ab, ex.y);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({bus.y_out, bus.x_out, bus.clear_out, bus.busy, bus.done, bus.aborted,
             bus.z_count, bus.w_seen, bus.sig} !== '0) begin
            errors++;
            $display("FAIL reset_values got y=%h x=%b clr=%b busy=%b done=%b ab=%b zc=%0d w=%b sig=%h exp all 0",
                     bus.y_out, bus.x_out, bus.clear_out, bus.busy, bus.done, bus.aborted,
                     bus.z_count, bus.w_seen, bus.sig);
        end
        @(negedge ck);
        rst_n = 1'b1;
        model_y = 32'h0;
        @(posedge ck); #1;
    endtask

    task automatic test_preset_clear();
        run_case("preset_clear", 5, 1'b1, 1'b1, 32'h0, 0, 0, -1, 1'b0);
    endtask

    task automatic test_zero_steps();
        run_case("zero_steps", 0, 1'b0, 1'b1, 32'h1234_5678, 0, 0, -1, 1'b0);
    endtask

    task automatic test_hold();
        run_case("hold", 4, 1'b0, 1'b1, 32'h0, 3, 3, -1, 1'b0);
    endtask

    task automatic test_abort();
        run_case("abort", 10, 1'b0, 1'b1, 32'h0, 0, 0, 3, 1'b0);
        run_case("after_abort", 3, 1'b0, 1'b0, 32'h0, 0, 0, -1, 1'b0);
        run_case("abort_in_clr", 5, 1'b1, 1'b1, 32'h0000_0077, 0, 0, 1, 1'b0);
        run_case("abort_last_step", 2, 1'b0, 1'b1, 32'h10, 2, 1, 2, 1'b0);
    endtask

    task automatic test_wrap_w();
        run_case("wrap_w", 3, 1'b0, 1'b1, 32'hFFFF_FFFE, 0, 0, -1, 1'b1);
    endtask

    task automatic test_sig();
        logic [15:0] want;
`ifdef S838_SIG_EN
        want = 16'hEFDF;
`else
        want = 16'h0000;
`endif
        run_case("sig", 1, 1'b0, 1'b1, 32'h0, 0, 0, -1, 1'b0);
        vectors++;
        if (bus.sig !== want) begin
            errors++;
            $display("FAIL sig_const got %h exp %h", bus.sig, want);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            int n;
            int hs;
            int hl;
            n  = int'($urandom_range(1, 20));
            hs = int'($urandom_range(1, 12));
            hl = int'($urandom_range(0, 3));
            run_case($sformatf("b2b%0d", i), n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom, hs, hl, -1, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_run();
        int saw_done;
        bus.start = 1'b1; bus.steps = STEP_W'(100); bus.clear_first = 1'b0;
        bus.ld_en = 1'b1; bus.ld_data = 32'h0;
        @(posedge ck); #1;
        idle_inputs();
        repeat (10) begin
            @(posedge ck); #1;
        end
        vectors++;
        if ({bus.busy, bus.y_out} !== {1'b1, 32'd10}) begin
            errors++;
            $display("FAIL rst_mid_pre got busy=%b y=%h exp 1/%h", bus.busy, bus.y_out, 32'd10);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.y_out, bus.busy, bus.done, bus.x_out, bus.z_count} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async got y=%h busy=%b done=%b x=%b zc=%0d exp 0",
                     bus.y_out, bus.busy, bus.done, bus.x_out, bus.z_count);
        end
        model_y = 32'h0;
        saw_done = 0;
        repeat (2) begin
            @(posedge ck); #1;
            if (bus.done === 1'b1) saw_done++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge ck); #1;
            if (bus.done === 1'b1) saw_done++;
        end
        vectors++;
        if (saw_done != 0) begin
            errors++;
            $display("FAIL rst_mid_no_done got %0d done cycles exp 0", saw_done);
        end
        run_case("after_reset", 4, 1'b0, 1'b0, 32'h0, 0, 0, -1, 1'b0);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_preset_clear();
        test_zero_steps();
        test_hold();
        test_abort();
        test_wrap_w();
        test_sig();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
